// File: rtl/conv_reg_full_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_reg_full_seq
// Purpose  : Sequencer and credit controller for the pipelined conv datapath.
//            Issues upstream frames to the datapath one per cycle, tags each
//            frame through the 8-bit opaque side channel, collects returning
//            results in a FIFO, and swaps filter weights only once the
//            datapath pipeline is empty.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_ready/in_img/in_tag      upstream frame stream
//            wt_valid/wt_ready/wt_data            weight-set load handshake
//            dp_img/dp_fil/dp_opaque_in           issue side of the datapath
//            dp_opaque_out/dp_result              return side of the datapath
//            out_valid/out_ready/out_data/out_tag result FIFO head
//            busy                                 frames in flight
//            err_unexp                            sticky unexpected-return flag
// Revision : 1.0 - initial release
// ============================================================================
module conv_reg_full_seq #(
    parameter int IMG_BITS   = 1024,
    parameter int FIL_BITS   = 576,
    parameter int RES_BITS   = 576,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMG_BITS-1:0] in_img,
    input  logic [6:0]          in_tag,
    input  logic                wt_valid,
    output logic                wt_ready,
    input  logic [FIL_BITS-1:0] wt_data,
    output logic [IMG_BITS-1:0] dp_img,
    output logic [FIL_BITS-1:0] dp_fil,
    output logic [7:0]          dp_opaque_in,
    input  logic [7:0]          dp_opaque_out,
    input  logic [RES_BITS-1:0] dp_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_BITS-1:0] out_data,
    output logic [6:0]          out_tag,
    output logic                busy,
    output logic                err_unexp
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W = RES_BITS + 7;
    // One extra bit so inflight + fifo_count cannot wrap before the compare.
    localparam logic [c_CNT_W:0]   c_DEPTH_SUM = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_inflight;
    logic [c_CNT_W-1:0]  r_fifo_count;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];

    logic                w_credit_ok;
    logic                w_accept;
    logic                w_ret;
    logic                w_ret_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic [c_ENT_W-1:0]  w_head;

    // A frame may only enter if a FIFO slot is guaranteed for its result.
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_fifo_count}) < c_DEPTH_SUM;

    // A pending weight request blocks new frames in the very same cycle.
    assign in_ready = (r_state == ST_RUN) && !wt_valid && w_credit_ok;
    assign wt_ready = (r_state == ST_LOAD);

    assign w_accept    = in_valid && in_ready;
    assign w_ret       = dp_opaque_out[7];
    assign w_ret_ok    = w_ret && (r_inflight != '0);
    assign w_pop       = out_valid && out_ready;
    assign w_fifo_full = (r_fifo_count == c_DEPTH_CNT);
    // Credited returns always fit; the full guard only matters for an
    // unexpected return, which must not corrupt the FIFO.
    assign w_push      = w_ret && (!w_fifo_full || w_pop);

    assign busy      = (r_inflight != '0);
    assign out_valid = (r_fifo_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    // Mask the head so the outputs read as zero while the FIFO is empty.
    assign out_tag   = out_valid ? w_head[c_ENT_W-1 -: 7]  : 7'd0;
    assign out_data  = out_valid ? w_head[RES_BITS-1:0]    : '0;

    // Control FSM; also owns the weight register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            dp_fil  <= '0;
        end else begin
            case (r_state)
                ST_INIT:  if (wt_valid) r_state <= ST_LOAD;
                ST_RUN:   if (wt_valid) r_state <= ST_DRAIN;
                ST_DRAIN: if (r_inflight == '0) r_state <= ST_LOAD;
                ST_LOAD: begin
                    dp_fil  <= wt_data;
                    r_state <= ST_RUN;
                end
                default:  r_state <= ST_INIT;
            endcase
        end
    end

    // Issue register: tag valid for exactly one cycle, image held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_img       <= '0;
            dp_opaque_in <= 8'h00;
        end else if (w_accept) begin
            dp_img       <= in_img;
            dp_opaque_in <= {1'b1, in_tag};
        end else begin
            dp_opaque_in <= 8'h00;
        end
    end

    // In-flight counter and sticky error. An unexpected return never
    // decrements, so the counter cannot underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
            err_unexp  <= 1'b0;
        end else begin
            if (w_accept && !w_ret_ok) begin
                r_inflight <= r_inflight + c_CNT_W'(1);
            end else if (!w_accept && w_ret_ok) begin
                r_inflight <= r_inflight - c_CNT_W'(1);
            end
            if (w_ret && (r_inflight == '0)) begin
                err_unexp <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap explicitly so any depth works.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_fifo_count <= r_fifo_count - c_CNT_W'(1);
            end
        end
    end

    // FIFO storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {dp_opaque_out[6:0], dp_result};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_reg_full_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_reg_full_seq
// Purpose  : Self-checking bench for conv_reg_full_seq. A latency-5 datapath
//            stand-in computes result = image + weights. Accepted frames push
//            their expected {tag, result} into a scoreboard queue; a monitor
//            pops and compares whenever the DUT hands out a result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_reg_full_seq;

    localparam int IMG_BITS   = 32;
    localparam int FIL_BITS   = 16;
    localparam int RES_BITS   = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int LAT        = 5;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [IMG_BITS-1:0] in_img;
    logic [6:0]          in_tag;
    logic                wt_valid;
    logic                wt_ready;
    logic [FIL_BITS-1:0] wt_data;
    logic [IMG_BITS-1:0] dp_img;
    logic [FIL_BITS-1:0] dp_fil;
    logic [7:0]          dp_opaque_in;
    logic [7:0]          dp_opaque_out;
    logic [RES_BITS-1:0] dp_result;
    logic                out_valid;
    logic                out_ready;
    logic [RES_BITS-1:0] out_data;
    logic [6:0]          out_tag;
    logic                busy;
    logic                err_unexp;

    conv_reg_full_seq #(
        .IMG_BITS   (IMG_BITS),
        .FIL_BITS   (FIL_BITS),
        .RES_BITS   (RES_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_img        (in_img),
        .in_tag        (in_tag),
        .wt_valid      (wt_valid),
        .wt_ready      (wt_ready),
        .wt_data       (wt_data),
        .dp_img        (dp_img),
        .dp_fil        (dp_fil),
        .dp_opaque_in  (dp_opaque_in),
        .dp_opaque_out (dp_opaque_out),
        .dp_result     (dp_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_tag       (out_tag),
        .busy          (busy),
        .err_unexp     (err_unexp)
    );

    // Clock: posedge at 5,15,...; inputs change at negedge, sampling at posedge-1.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: fixed latency, result = image + weights.
    logic                inject;
    logic [7:0]          p_op  [LAT];
    logic [RES_BITS-1:0] p_res [LAT];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                p_op[i]  <= '0;
                p_res[i] <= '0;
            end
        end else begin
            p_op[0]  <= dp_opaque_in;
            p_res[0] <= dp_img + RES_BITS'(dp_fil);
            for (int i = 1; i < LAT; i++) begin
                p_op[i]  <= p_op[i-1];
                p_res[i] <= p_res[i-1];
            end
        end
    end

    assign dp_opaque_out = inject ? 8'h85 : p_op[LAT-1];
    assign dp_result     = inject ? 32'hCAFE_F00D : p_res[LAT-1];

    // Scoreboard and counters.
    logic [RES_BITS+6:0] sb [$];
    logic [FIL_BITS-1:0] fil_model;
    logic                rec_pops;
    int                  pop_cyc [$];
    int                  errors = 0;
    int                  checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus-side recorder: every accepted frame yields its expected result,
    // computed with the most recently accepted weight set.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            if (in_valid && in_ready)
                sb.push_back({in_tag, in_img + RES_BITS'(fil_model)});
            if (wt_valid && wt_ready)
                fil_model = wt_data;
        end
    end

    // Monitor: compares every result the DUT hands downstream.
    always begin
        logic [RES_BITS+6:0] exp;
        @(negedge clk);
        #4;
        if (reset && out_valid && out_ready) begin
            if (rec_pops) pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: tag %0h data %0h, nothing expected", out_tag, out_data);
            end else begin
                exp = sb.pop_front();
                chk("out_tag", 64'(out_tag), 64'(exp[RES_BITS+6:RES_BITS]));
                chk("out_data", 64'(out_data), 64'(exp[RES_BITS-1:0]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic look();
        #4;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_in_ready"},     64'(in_ready),     64'd0);
        chk({p, "_wt_ready"},     64'(wt_ready),     64'd0);
        chk({p, "_dp_img"},       64'(dp_img),       64'd0);
        chk({p, "_dp_fil"},       64'(dp_fil),       64'd0);
        chk({p, "_dp_opaque_in"}, 64'(dp_opaque_in), 64'd0);
        chk({p, "_out_valid"},    64'(out_valid),    64'd0);
        chk({p, "_out_data"},     64'(out_data),     64'd0);
        chk({p, "_out_tag"},      64'(out_tag),      64'd0);
        chk({p, "_busy"},         64'(busy),         64'd0);
        chk({p, "_err_unexp"},    64'(err_unexp),    64'd0);
    endtask

    task automatic wait_idle(input string p);
        int n = 0;
        look();
        while ((busy || out_valid || sb.size() != 0) && n < 100) begin
            step();
            look();
            n++;
        end
        chk({p, "_idle"}, 64'(busy || out_valid), 64'd0);
        chk({p, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int acc;
        int rets;
        int last_ret;
        logic bad;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_img    = '0;
        in_tag    = '0;
        wt_valid  = 1'b0;
        wt_data   = '0;
        out_ready = 1'b0;
        inject    = 1'b0;
        fil_model = '0;
        rec_pops  = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) step();
        look();
        check_reset_vals("rst");
        step();
        reset = 1'b1;

        // ---------------- startup ----------------
        in_valid  = 1'b1;
        in_img    = $urandom;
        in_tag    = 7'h11;
        out_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            look();
            if (in_ready) bad = 1'b1;
        end
        chk("init_in_ready_low", 64'(bad), 64'd0);

        step();
        wt_valid = 1'b1;
        wt_data  = 16'h12A5;
        look();
        n = 0;
        while (!wt_ready && n < 10) begin
            step();
            look();
            n++;
        end
        chk("startup_wt_ready", 64'(wt_ready), 64'd1);
        step();
        wt_valid = 1'b0;
        look();
        chk("startup_wt_ready_pulse", 64'(wt_ready), 64'd0);
        chk("startup_dp_fil", 64'(dp_fil), 64'h12A5);
        chk("startup_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        wait_idle("startup");

        // ---------------- streaming ----------------
        step();
        rec_pops = 1'b1;
        pop_cyc.delete();
        k = 0;
        n = 0;
        while (k < 20 && n < 60) begin
            if (n != 0) step();
            in_valid = 1'b1;
            in_tag   = 7'(k);
            in_img   = $urandom;
            look();
            if (in_ready) k++;
            n++;
        end
        chk("stream_cycles", 64'(n), 64'd20);
        step();
        in_valid = 1'b0;
        last_ret = -10;
        n = 0;
        look();
        while (n < 60) begin
            if (dp_opaque_out[7]) last_ret = cyc;
            if (!busy) break;
            step();
            look();
            n++;
        end
        chk("stream_busy_low", 64'(busy), 64'd0);
        chk("stream_busy_fall", 64'(cyc), 64'(last_ret + 1));
        wait_idle("stream");
        chk("stream_pop_count", 64'(pop_cyc.size()), 64'd20);
        if (pop_cyc.size() == 20)
            chk("stream_no_bubbles", 64'(pop_cyc[19] - pop_cyc[0]), 64'd19);
        rec_pops = 1'b0;

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            in_valid = 1'b1;
            in_tag   = 7'(8'h40 + i);
            in_img   = $urandom;
            look();
            if (in_ready) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'(FIFO_DEPTH));
        step();
        in_valid = 1'b0;
        n = 0;
        look();
        while (busy && n < 40) begin
            step();
            look();
            n++;
        end
        chk("bp_full_out_valid", 64'(out_valid), 64'd1);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        look();
        chk("bp_in_ready_before_credit", 64'(in_ready), 64'd0);
        step();
        look();
        chk("bp_in_ready_after_credit", 64'(in_ready), 64'd1);
        wait_idle("bp");

        // ---------------- weight swap mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b1;
            in_tag   = 7'(8'h60 + i);
            in_img   = $urandom;
            look();
            chk("ws_accept", 64'(in_ready), 64'd1);
        end
        step();
        wt_valid = 1'b1;
        wt_data  = 16'h3C5A;
        in_tag   = 7'h63;
        in_img   = $urandom;
        look();
        chk("ws_in_ready_drop", 64'(in_ready), 64'd0);
        rets = 0;
        n = 0;
        bad = 1'b0;
        while (n < 40) begin
            if (wt_ready) break;
            if (dp_opaque_out[7]) rets++;
            if (in_ready) bad = 1'b1;
            step();
            look();
            n++;
        end
        chk("ws_wt_ready", 64'(wt_ready), 64'd1);
        chk("ws_returns_before_load", 64'(rets), 64'd3);
        chk("ws_no_issue_while_draining", 64'(bad), 64'd0);
        step();
        wt_valid = 1'b0;
        look();
        chk("ws_new_dp_fil", 64'(dp_fil), 64'h3C5A);
        chk("ws_in_ready_resume", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            in_tag = 7'(8'h64 + i);
            in_img = $urandom;
        end
        step();
        in_valid = 1'b0;
        wait_idle("ws");

        // ---------------- spurious return ----------------
        step();
        out_ready = 1'b0;
        inject    = 1'b1;
        step();
        inject = 1'b0;
        look();
        chk("spur_err_set", 64'(err_unexp), 64'd1);
        chk("spur_inflight_zero", 64'(busy), 64'd0);
        chk("spur_entry_pushed", 64'(out_valid), 64'd1);
        sb.push_back({7'h05, 32'hCAFE_F00D});
        step();
        out_ready = 1'b1;
        repeat (3) step();
        look();
        chk("spur_err_sticky", 64'(err_unexp), 64'd1);
        chk("spur_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- reset mid-stream ----------------
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            in_valid = 1'b1;
            in_tag   = 7'(8'h70 + i);
            in_img   = $urandom;
            look();
            chk("rm_accept", 64'(in_ready), 64'd1);
        end
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #2;
        chk("rm_pre_busy", 64'(busy), 64'd1);
        chk("rm_pre_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("rm");
        sb.delete();
        fil_model = '0;
        repeat (2) step();
        reset    = 1'b1;
        in_valid = 1'b1;
        repeat (2) step();
        look();
        chk("rm_init_in_ready", 64'(in_ready), 64'd0);
        chk("rm_init_wt_ready", 64'(wt_ready), 64'd0);
        chk("rm_init_out_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
